// File: rtl/xil_dmem_tp_8x16.sv
// Distributed two-port 8x16 memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset, matching the LUT-RAM primitive.
module xil_dmem_tp_8x16 (
  input  logic        clk_wr,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_adr,
  input  logic [15:0] i_wr_data,
  input  logic [2:0]  i_rd_adr,
  output logic [15:0] o_rd_data
);

  logic [15:0] mem [8];

  always_ff @(posedge clk_wr) begin
    if (i_wr_en) begin
      mem[i_wr_adr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_adr];

endmodule

// File: rtl/fifo_fwft_8x16.sv
// 8-entry x 16-bit first-word-fall-through FIFO with occupancy, threshold flags and
// sticky overflow/underflow error flags, built around the distributed two-port memory.
module fifo_fwft_8x16 #(
  parameter int AFULL_THRES  = 6,
  parameter int AEMPTY_THRES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_wr_data,
  input  logic        i_wr_en,
  output logic        o_full,
  output logic        o_afull,
  input  logic        i_rd_en,
  output logic [15:0] o_rd_data,
  output logic        o_empty,
  output logic        o_aempty,
  output logic [3:0]  o_level,
  output logic        o_overflow,
  output logic        o_underflow,
  input  logic        i_clr_err
);

  localparam int PTR_W = 3;
  localparam int LVL_W = 4;
  localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(8);
  localparam logic [LVL_W-1:0] AFULL_LVL  = LVL_W'(AFULL_THRES);
  localparam logic [LVL_W-1:0] AEMPTY_LVL = LVL_W'(AEMPTY_THRES);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_acc, rd_acc;

  // Flags decode only registered state, so the sole input-to-output path is the memory read.
  assign o_full   = (level_reg == DEPTH_LVL);
  assign o_empty  = (level_reg == '0);
  assign o_afull  = (level_reg >= AFULL_LVL);
  assign o_aempty = (level_reg <= AEMPTY_LVL);
  assign o_level  = level_reg;
  assign o_overflow  = overflow_reg;
  assign o_underflow = underflow_reg;

  assign wr_acc = i_wr_en & ~o_full;
  assign rd_acc = i_rd_en & ~o_empty;

  always_comb begin
    wr_ptr_next    = wr_acc ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next    = rd_acc ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    level_next     = level_reg + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (i_clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    // A fresh error in the clearing cycle must not be lost.
    if (i_wr_en && o_full) begin
      overflow_next = 1'b1;
    end
    if (i_rd_en && o_empty) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // The full check keeps the write address off every unread entry, so no bypass is needed.
  xil_dmem_tp_8x16 u_mem (
    .clk_wr    (clk),
    .i_wr_en   (wr_acc),
    .i_wr_adr  (wr_ptr_reg),
    .i_wr_data (i_wr_data),
    .i_rd_adr  (rd_ptr_reg),
    .o_rd_data (o_rd_data)
  );

endmodule
